// File: rtl/approx_mult_pkg.sv
// Shared constants and state type for the sequential nibble-decomposed approximate multiplier.
package approx_mult_pkg;
   localparam int NIB = 4;

   localparam logic [1:0] MODE_EXACT = 2'd0;
   localparam logic [1:0] MODE_OR    = 2'd1;
   localparam logic [1:0] MODE_TRUNC = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/nib_mult_4x4.sv
// Exact 4x4 unsigned multiplier, 8-bit product; purely combinational.
module nib_mult_4x4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);
   assign p = {4'b0, a} * {4'b0, b};
endmodule

// File: rtl/approx_mult_seq.sv
// Sequential WIDTH x WIDTH approximate multiplier: one 4x4 partial product per cycle,
// combined by exact add, OR-merge or low-block truncation. Optional: APPROX_MULT_ZERO_SKIP_EN.
module approx_mult_seq
   import approx_mult_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int TRUNC_LVL = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [1:0]         mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] R
);
   localparam int N  = WIDTH / NIB;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int RW = 2 * WIDTH;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [1:0]       mode_q;
   logic [RW-1:0]    acc_q, acc_nxt, acc_sum, pp_sh;
   logic [IW-1:0]    idx_i, idx_j;
   logic [NIB-1:0]   a_nib, b_nib;
   logic [7:0]       pp;
   logic             last, zskip;
   int               ij_sum;

   assign a_nib  = NIB'(a_q >> (NIB * idx_i));
   assign b_nib  = NIB'(b_q >> (NIB * idx_j));
   assign ij_sum = int'(idx_i) + int'(idx_j);
   assign last   = (idx_i == IW'(N - 1)) && (idx_j == IW'(N - 1));

   nib_mult_4x4 u_nib (
      .a (a_nib),
      .b (b_nib),
      .p (pp)
   );

   assign pp_sh   = RW'(pp) << (NIB * ij_sum);
   assign acc_sum = acc_q + pp_sh;

`ifdef APPROX_MULT_ZERO_SKIP_EN
   // Checked on the latched operands during the first CALC cycle.
   assign zskip = (a_q == '0) || (b_q == '0);
`else
   assign zskip = 1'b0;
`endif

   always_comb begin
      acc_nxt = acc_sum;
      case (mode_q)
         MODE_EXACT: acc_nxt = acc_sum;
         MODE_OR:    acc_nxt = acc_q | pp_sh;
         MODE_TRUNC: acc_nxt = (ij_sum >= TRUNC_LVL) ? acc_sum : acc_q;
         default:    acc_nxt = acc_sum;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)         state_d = CALC;
         CALC:    if (zskip || last)    state_d = DONE;
         DONE:    if (out_ready)        state_d = IDLE;
         default:                       state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= '0;
         acc_q   <= '0;
         idx_i   <= '0;
         idx_j   <= '0;
         R       <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (in_valid) begin
               a_q    <= A;
               b_q    <= B;
               mode_q <= mode;
               acc_q  <= '0;
               idx_i  <= '0;
               idx_j  <= '0;
            end
            CALC: begin
               if (zskip) begin
                  R <= '0;
               end else begin
                  acc_q <= acc_nxt;
                  if (last) R <= acc_nxt;
                  // i walks the multiplicand nibbles fastest, j advances on wrap
                  else if (idx_i == IW'(N - 1)) begin
                     idx_i <= '0;
                     idx_j <= idx_j + 1'b1;
                  end else begin
                     idx_i <= idx_i + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/approx_mult_seq.md
Name: approx_mult_seq

Overview:
- Parametrised, sequential successor to the fixed 8x8 nibble-decomposed approximate multipliers.
- Splits WIDTH x WIDTH unsigned operands into 4-bit nibbles and computes one 4x4 partial product per cycle.
- Combines partial products with a runtime-selectable rule: exact add, OR-merge or low-block truncation.
- Sits behind a valid/ready handshake so accelerator datapaths can stream operands through it.

Parameters:
- WIDTH, 8, operand width; must be a multiple of 4 and at least 8. N = WIDTH/4 nibbles per operand.
- TRUNC_LVL, 1, in truncate mode, partial products with i+j < TRUNC_LVL are skipped.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  multiplicand, unsigned.
- B  input  WIDTH  multiplier, unsigned.
- mode  input  2  combine mode: 0 exact, 1 OR-merge, 2 truncate, 3 reserved.
- out_valid  output  1  result R valid.
- out_ready  input  1  consumer accepts R.
- R  output  2*WIDTH  product.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous, active-low. All state updates on the rising edge of clk.
- Reset values: in_ready=1, out_valid=0, R=0, accumulator=0, counter=0, state=IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch A, B and mode, clear the accumulator, set k=0, go to CALC.
  - CALC: in_ready=0. Each cycle processes index k (i = k mod N, j = k div N).
    - pp = A[4i+3:4i] * B[4j+3:4j], 8 bits exact; shift s = 4(i+j).
    - mode 0: acc = acc + (pp<<s).
    - mode 1: acc = acc | (pp<<s).
    - mode 2: acc = acc + (pp<<s) if i+j >= TRUNC_LVL, otherwise acc is unchanged.
    - mode 3: treated as mode 0.
    - When k = N*N-1, go to DONE; otherwise k = k+1.
  - DONE: out_valid=1, R=acc, held stable until out_ready. On out_valid&&out_ready, go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
- Latency: operands accepted at edge t give out_valid high after edge t+N*N. Throughput is one result per N*N+2 cycles with out_ready held high.
- Arithmetic:
  - The accumulator is 2*WIDTH bits; carries beyond bit 2*WIDTH-1 are discarded (cannot occur in mode 0).
  - Result is unsigned.
- Boundary conditions:
  - in_valid in CALC or DONE is ignored and does not stall the FSM.
  - Operands and mode are sampled only at acceptance; later input changes have no effect.
  - out_ready asserted while not in DONE is ignored.
  - rst_n low in any state returns to IDLE at the next edge and discards any result in flight.
  - TRUNC_LVL=0 makes mode 2 identical to mode 0.

Optional Feature:
- Macro: APPROX_MULT_ZERO_SKIP_EN.
- Defined: if the latched A==0 or B==0 at acceptance, skip CALC and go directly IDLE->DONE with R=0. Latency is 1 cycle (out_valid high after edge t+1).
- Undefined: zero operands take the full N*N CALC cycles and yield R=0.

Decomposition:
- Shared package approx_mult_pkg:
  - mode constants MODE_EXACT=0, MODE_OR=1, MODE_TRUNC=2.
  - state enum IDLE/CALC/DONE.
  - NIB=4 constant.
- One sub-module: nib_mult_4x4, a combinational exact 4x4 unsigned multiplier with an 8-bit result, instantiated once and time-shared across the N*N cycles.
- The shift/combine logic and the FSM stay in the top module.

Test Plan:
- WIDTH=8, mode 0, A=0xFF, B=0xFF -> R=0xFE01, out_valid after 4 CALC cycles (edge t+4); also sweep random operands against a reference model.
- WIDTH=8, mode 1, A=0xFF, B=0xFF -> R=0xEFF1 (0x00E1 | 0x0E10 | 0x0E10 | 0xE100).
- WIDTH=8, mode 2, TRUNC_LVL=1, A=0xFF, B=0xFF -> R=0xFD20; mode 3 with the same operands -> R=0xFE01.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing A -> R stable, in_ready=0, no new acceptance; release -> next operands accepted, in_ready high 1 cycle after the handshake.
- Reset mid-CALC: rst_n=0 at k=2 -> next edge out_valid=0, in_ready=1, R=0; a subsequent 0x12*0x34 in mode 0 -> R=0x03A8.
- WIDTH=16, mode 0, A=0xFFFF, B=0x0002 -> R=0x0001FFFE after 16 CALC cycles; with APPROX_MULT_ZERO_SKIP_EN, A=0 -> R=0 at edge t+1.
